// File: rtl/agc_pkg.sv
// Shared AGC definitions: word geometry, opcode/quarter-code constants, fetch/decode FSM states.
// Also holds the instruction legality rule used by the fetch/decode stage.
package agc_pkg;

    localparam int unsigned WORD_W = 15;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned QC_W   = 2;

    localparam logic [OP_W-1:0] OpTc     = 3'd0;
    localparam logic [OP_W-1:0] OpCcs    = 3'd1;
    localparam logic [OP_W-1:0] OpCs     = 3'd4;
    localparam logic [OP_W-1:0] OpIdxGrp = 3'd5;
    localparam logic [OP_W-1:0] OpAd     = 3'd6;
    localparam logic [OP_W-1:0] OpMask   = 3'd7;

    localparam logic [QC_W-1:0] QcIndex  = 2'd0;
    localparam logic [QC_W-1:0] QcExtend = 2'd1;
    localparam logic [QC_W-1:0] QcTs     = 2'd2;
    localparam logic [QC_W-1:0] QcXch    = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StApply
    } ifd_state_e;

    // The quarter code never affects legality: every opcode-5 form is defined.
    function automatic logic is_illegal(input logic [OP_W-1:0] op, input logic ext);
        logic legal;
        if (ext) begin
            legal = (op == OpCcs) || (op == OpAd) || (op == OpMask);
        end else begin
            legal = (op == OpTc) || (op == OpCcs) || (op == OpCs) || (op == OpIdxGrp) ||
                    (op == OpAd) || (op == OpMask);
        end
        return !legal;
    endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Fetch/decode bus between the control FSM (master) and instr_fetch_decode (slave).
// Optional illegal_cnt signal present only when IFD_ILLEGAL_CNT_EN is defined.
interface instr_fetch_decode_if;
    import agc_pkg::*;

    logic              b_wr;
    logic [WORD_W-1:0] mem_rdata;
    logic              ext_flag;
    logic              index_wr;
    logic [WORD_W-1:0] index_data;

    logic [WORD_W-1:0] instr;
    logic [OP_W-1:0]   opcode;
    logic [QC_W-1:0]   qc;
    logic [11:0]       addr12;
    logic [9:0]        addr10;
    logic              extracode;
    logic              decode_valid;
    logic              illegal;
`ifdef IFD_ILLEGAL_CNT_EN
    logic [7:0]        illegal_cnt;
`endif

    modport master (
        output b_wr, mem_rdata, ext_flag, index_wr, index_data,
        input  instr, opcode, qc, addr12, addr10, extracode, decode_valid, illegal
`ifdef IFD_ILLEGAL_CNT_EN
        , input illegal_cnt
`endif
    );

    modport slave (
        input  b_wr, mem_rdata, ext_flag, index_wr, index_data,
        output instr, opcode, qc, addr12, addr10, extracode, decode_valid, illegal
`ifdef IFD_ILLEGAL_CNT_EN
        , output illegal_cnt
`endif
    );

endinterface

// File: rtl/ones_comp_add.sv
// Ones'-complement adder with end-around carry; shared between instruction indexing and the ALU.
module ones_comp_add #(
    parameter int unsigned Width = 15
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    output logic [Width-1:0] sum
);

    logic [Width:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        sum = raw[Width-1:0] + Width'(raw[Width]);
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode stage: capture on b_wr, apply pending INDEX, decode fields two cycles on.
// Define IFD_ILLEGAL_CNT_EN to add the saturating illegal-decode counter output.
module instr_fetch_decode
    import agc_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    instr_fetch_decode_if.slave bus
);

    ifd_state_e state_q, state_d;

    logic [WORD_W-1:0] raw_q;
    logic              ext_cap_q;
    logic              use_idx_q;
    logic [WORD_W-1:0] idx_snap_q;
    logic              newer_q;
    logic              index_pend_q;
    logic [WORD_W-1:0] index_val_q;
    logic [WORD_W-1:0] instr_q;
    logic              extracode_q;
    logic              illegal_q;

    logic [WORD_W-1:0] idx_sum;
    logic [WORD_W-1:0] applied;
    logic              idx_clr;
    logic              load;

    ones_comp_add #(
        .Width(WORD_W)
    ) u_idx_add (
        .a  (raw_q),
        .b  (idx_snap_q),
        .sum(idx_sum)
    );

    assign applied = use_idx_q ? idx_sum : raw_q;
    assign load    = (state_q == StCapture) && !bus.b_wr;
    // Only the index this word actually took is retired; a newer write stays pending.
    assign idx_clr = (state_q == StApply) && use_idx_q && !newer_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    state_d = bus.b_wr ? StCapture : StIdle;
            StCapture: state_d = bus.b_wr ? StCapture : StApply;
            StApply:   state_d = bus.b_wr ? StCapture : StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.decode_valid = 1'b0;
        if (state_q == StApply) begin
            bus.decode_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q        <= '0;
            ext_cap_q    <= 1'b0;
            use_idx_q    <= 1'b0;
            idx_snap_q   <= '0;
            newer_q      <= 1'b0;
            index_pend_q <= 1'b0;
            index_val_q  <= '0;
            instr_q      <= '0;
            extracode_q  <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            // Snapshot the index as it stood before this cycle's index_wr.
            if (bus.b_wr) begin
                raw_q      <= bus.mem_rdata;
                ext_cap_q  <= bus.ext_flag;
                use_idx_q  <= index_pend_q && !idx_clr;
                idx_snap_q <= index_val_q;
                newer_q    <= bus.index_wr;
            end else if (bus.index_wr) begin
                newer_q <= 1'b1;
            end

            if (bus.index_wr) begin
                index_pend_q <= 1'b1;
                index_val_q  <= bus.index_data;
            end else if (idx_clr) begin
                index_pend_q <= 1'b0;
            end

            if (load) begin
                instr_q     <= applied;
                extracode_q <= ext_cap_q;
                illegal_q   <= is_illegal(applied[WORD_W-1 -: OP_W], ext_cap_q);
            end
        end
    end

`ifdef IFD_ILLEGAL_CNT_EN
    logic [7:0] illegal_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt_q <= 8'd0;
        end else if ((state_q == StApply) && illegal_q && (illegal_cnt_q != 8'hFF)) begin
            illegal_cnt_q <= illegal_cnt_q + 8'd1;
        end
    end

    assign bus.illegal_cnt = illegal_cnt_q;
`endif

    assign bus.instr     = instr_q;
    assign bus.opcode    = instr_q[WORD_W-1 -: OP_W];
    assign bus.qc        = instr_q[WORD_W-OP_W-1 -: QC_W];
    assign bus.addr12    = instr_q[11:0];
    assign bus.addr10    = instr_q[9:0];
    assign bus.extracode = extracode_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: directed cases then random traffic vs a fetch-level model.
// Exercises illegal_cnt when IFD_ILLEGAL_CNT_EN is defined.
module tb_instr_fetch_decode;
    import agc_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instr_fetch_decode_if bus ();

    instr_fetch_decode dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit          valid;
        logic [14:0] word;
        bit          ext;
        bit          use_idx;
        logic [14:0] val;
        int unsigned gen;
    } fetch_t;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // fa: fetch started last cycle; fb: fetch whose decode is visible this cycle
    fetch_t      fa, fb;
    bit          pend;
    logic [14:0] pval;
    int unsigned pgen;
    logic [14:0] e_instr;
    bit          e_ext, e_ill, e_dv;
    int unsigned e_cnt;

    function automatic logic [14:0] oc_add(input logic [14:0] a, input logic [14:0] b);
        int s;
        s = int'(a) + int'(b);
        if (s > 32767) s = s - 32767;
        return 15'(s);
    endfunction

    function automatic bit ref_illegal(input logic [14:0] w, input bit ext);
        int op;
        op = int'(w) / 4096;
        if (ext) return !(op == 1 || op == 6 || op == 7);
        return (op == 2 || op == 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("dv", 32'(bus.decode_valid), 32'(e_dv));
        chk("instr", 32'(bus.instr), 32'(e_instr));
        chk("opcode", 32'(bus.opcode), 32'(e_instr) >> 12);
        chk("qc", 32'(bus.qc), (32'(e_instr) >> 10) & 32'h3);
        chk("addr12", 32'(bus.addr12), 32'(e_instr) & 32'hFFF);
        chk("addr10", 32'(bus.addr10), 32'(e_instr) & 32'h3FF);
        chk("extracode", 32'(bus.extracode), 32'(e_ext));
        chk("illegal", 32'(bus.illegal), 32'(e_ill));
`ifdef IFD_ILLEGAL_CNT_EN
        chk("illegal_cnt", 32'(bus.illegal_cnt), e_cnt);
`endif
    endtask

    task automatic step(input bit bw, input logic [14:0] w, input bit ext, input bit iw,
                        input logic [14:0] idat, input bit r);
        fetch_t nf;
        @(posedge clk);
        #1;
        e_dv = fb.valid;
        if (fb.valid) begin
            e_instr = fb.use_idx ? oc_add(fb.word, fb.val) : fb.word;
            e_ext   = fb.ext;
            e_ill   = ref_illegal(e_instr, e_ext);
        end
        model_check();

        bus.b_wr       = bw;
        bus.mem_rdata  = w;
        bus.ext_flag   = ext;
        bus.index_wr   = iw;
        bus.index_data = idat;
        rst            = r;

        if (fb.valid && e_ill && e_cnt < 255) e_cnt++;
        if (r) begin
            pend = 0; pval = '0; fa.valid = 0; fb.valid = 0;
            e_instr = '0; e_ext = 0; e_ill = 0; e_cnt = 0;
        end else begin
            // A completed fetch retires the index it used unless a newer one was written.
            if (fb.valid && fb.use_idx && pgen == fb.gen) pend = 0;
            nf.valid = bw; nf.word = w; nf.ext = ext;
            nf.use_idx = pend; nf.val = pval; nf.gen = pgen;
            fb = fa;
            fb.valid = fa.valid && !bw;
            fa = nf;
            if (iw) begin
                pend = 1; pval = idat; pgen++;
            end
        end
    endtask

    task automatic fetch(input logic [14:0] w, input bit ext);
        step(1, w, ext, 0, 15'($urandom), 0);
    endtask

    task automatic idle();
        step(0, 15'($urandom), 1'($urandom), 0, 15'($urandom), 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.b_wr = 0; bus.mem_rdata = '0; bus.ext_flag = 0;
        bus.index_wr = 0; bus.index_data = '0;
        fa = '{default: 0}; fb = '{default: 0};
        pend = 0; pval = '0; pgen = 0;
        e_instr = '0; e_ext = 0; e_ill = 0; e_dv = 0; e_cnt = 0;
        repeat (3) @(posedge clk);

        idle();
        chk("rst_dv", 32'(bus.decode_valid), 32'd0);
        chk("rst_instr", 32'(bus.instr), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);

        fetch(15'h6123, 0); idle(); idle();
        chk("plain_dv", 32'(bus.decode_valid), 32'd1);
        chk("plain_op", 32'(bus.opcode), 32'd6);
        chk("plain_qc", 32'(bus.qc), 32'd0);
        chk("plain_addr12", 32'(bus.addr12), 32'h123);
        chk("plain_illegal", 32'(bus.illegal), 32'd0);

        fetch(15'h7005, 1); idle(); idle();
        chk("ext_op", 32'(bus.opcode), 32'd7);
        chk("ext_flag", 32'(bus.extracode), 32'd1);
        chk("ext_legal", 32'(bus.illegal), 32'd0);
        fetch(15'h0005, 1); idle(); idle();
        chk("ext_illegal", 32'(bus.illegal), 32'd1);

        step(0, '0, 0, 1, 15'h0001, 0);
        fetch(15'h7FFF, 0); idle(); idle();
        chk("idx_eac", 32'(bus.instr), 32'h0001);
        fetch(15'h1000, 0); idle(); idle();
        chk("idx_cleared", 32'(bus.instr), 32'h1000);

        step(1, 15'h2000, 0, 1, 15'h0002, 0); idle(); idle();
        chk("idx_same_cycle", 32'(bus.instr), 32'h2000);
        fetch(15'h2000, 0); idle(); idle();
        chk("idx_next_fetch", 32'(bus.instr), 32'h2002);

        fetch(15'h1111, 0); fetch(15'h4444, 0); idle();
        chk("abort_no_dv", 32'(bus.decode_valid), 32'd0);
        idle();
        chk("abort_dv", 32'(bus.decode_valid), 32'd1);
        chk("abort_instr", 32'(bus.instr), 32'h4444);

        fetch(15'h5555, 0); step(0, '0, 0, 0, '0, 1); idle();
        chk("rst_mid_dv", 32'(bus.decode_valid), 32'd0);
        chk("rst_mid_instr", 32'(bus.instr), 32'd0);
        idle();
        chk("rst_mid_dv2", 32'(bus.decode_valid), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 4, 15'($urandom), 1'($urandom),
                 $urandom_range(0, 9) < 2, 15'($urandom), $urandom_range(0, 99) == 0);
        end

`ifdef IFD_ILLEGAL_CNT_EN
        step(0, '0, 0, 0, '0, 1);
        for (int i = 0; i < 300; i++) begin
            fetch(15'h2000, 0); idle(); idle();
        end
        idle();
        chk("cnt_sat", 32'(bus.illegal_cnt), 32'd255);
`endif

        idle(); idle(); idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
